// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;
  localparam int WIDTH_DEF = 64;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_iter_64_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_iter_64_if import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the quotient MSB into the partial
// remainder and subtracts the divisor magnitude when it fits.
module div_step import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             ge_s;

  // Shifted remainder needs one extra bit; the difference itself always fits in WIDTH.
  always_comb begin
    rem_sh_s = {rem, q[WIDTH-1]};
    ge_s     = (rem_sh_s >= {1'b0, divisor_mag});
    diff_s   = rem_sh_s[WIDTH-1:0] - divisor_mag;
    if (ge_s) begin
      rem_next = diff_s;
    end else begin
      rem_next = rem_sh_s[WIDTH-1:0];
    end
    q_next = {q[WIDTH-2:0], ge_s};
  end
endmodule

// File: rtl/div_iter_64.sv
// Iterative restoring divider for UDIV/SDIV: magnitudes are divided one bit
// per cycle, then signs are applied in a final FIX cycle.
module div_iter_64 import div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  div_iter_64_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] dvd_raw_r;
  logic             qneg_r;
  logic             rneg_r;
  logic             zero_r;
  logic             zwait_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rmd_r;
  logic             dbz_r;

  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] q_nx_s;
  logic [WIDTH-1:0] dd_mag_s;
  logic [WIDTH-1:0] dv_mag_s;
  logic             dd_neg_s;
  logic             dv_neg_s;

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
    if (neg) begin
      return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rmd_r;
  assign bus.div_by_zero = dbz_r;

  // Operand magnitudes; the most-negative value maps onto its own bit pattern.
  always_comb begin
    dd_neg_s = bus.signed_op & bus.dividend[WIDTH-1];
    dv_neg_s = bus.signed_op & bus.divisor[WIDTH-1];
    dd_mag_s = cond_neg(dd_neg_s, bus.dividend);
    dv_mag_s = cond_neg(dv_neg_s, bus.divisor);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_r),
    .q           (q_r),
    .divisor_mag (dvs_r),
    .rem_next    (rem_nx_s),
    .q_next      (q_nx_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      dvs_r     <= {WIDTH{1'b0}};
      dvd_raw_r <= {WIDTH{1'b0}};
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
      zero_r    <= 1'b0;
      zwait_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      quo_r     <= {WIDTH{1'b0}};
      rmd_r     <= {WIDTH{1'b0}};
      dbz_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            rem_r     <= {WIDTH{1'b0}};
            q_r       <= dd_mag_s;
            dvs_r     <= dv_mag_s;
            dvd_raw_r <= bus.dividend;
            qneg_r    <= dd_neg_s ^ dv_neg_s;
            rneg_r    <= dd_neg_s;
            cnt_r     <= CNT_W'(WIDTH - 1);
            dbz_r     <= 1'b0;
            busy_r    <= 1'b1;
            // A zero divisor skips the iterations but spends two cycles in FIX.
            if (bus.divisor == {WIDTH{1'b0}}) begin
              zero_r  <= 1'b1;
              zwait_r <= 1'b1;
              state_r <= FIX;
            end else begin
              zero_r  <= 1'b0;
              zwait_r <= 1'b0;
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          rem_r <= rem_nx_s;
          q_r   <= q_nx_s;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == {CNT_W{1'b0}}) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          if (zwait_r) begin
            zwait_r <= 1'b0;
          end else begin
            if (zero_r) begin
              quo_r <= {WIDTH{1'b0}};
              rmd_r <= dvd_raw_r;
              dbz_r <= 1'b1;
            end else begin
              quo_r <= cond_neg(qneg_r, q_r);
              rmd_r <= cond_neg(rneg_r, rem_r);
              dbz_r <= 1'b0;
            end
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule
